ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller that sequences the synchronous single-port instruction ROM (`blk_mem_gen_1`: registered address, 1-cycle read latency, 10-bit word address, 32-bit data). It owns the fetch PC, issues ROM reads, buffers returned words in a 2-entry queue, and presents them to decode over a valid/ready handshake. It also handles branch/jump redirects with flush and, optionally, a debug read port that shares the ROM.

## Interface

**Parameters**
- `AW`, 10: ROM word-address width.
- `RESET_PC`, 32'h0000_0000: byte address fetched after reset; bits [1:0] are ignored.

**Ports**
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rom_en` out 1: ROM read enable (combinational).
- `rom_addr` out AW: ROM word address, equal to `issue_pc[AW+1:2]` (combinational).
- `rom_data` in 32: ROM read data; valid the cycle after `rom_en`.
- `redirect_valid` in 1: single-cycle redirect strobe.
- `redirect_pc` in 32: redirect target byte address; bits [1:0] are forced to 0.
- `inst_valid` out 1: queue head is valid.
- `inst_ready` in 1: decode accepts the head this cycle.
- `inst` out 32: instruction word at the queue head.
- `inst_pc` out 32: byte address of `inst`.
- `dbg_req` in 1: debug read request (only with `IFETCH_DBG_EN`).
- `dbg_addr` in AW: debug word address.
- `dbg_ack` out 1: debug read completion pulse.
- `dbg_data` out 32: debug read data; valid while `dbg_ack` is high.

## Operation

- **FSM states:** BOOT and RUN.
  - `rst` forces BOOT.
  - BOOT lasts exactly one cycle with no issue, then moves to RUN.
  - RUN persists until the next reset.
- **Reset values:** `inst_valid`=0, `inst`=0, `inst_pc`=0, `dbg_ack`=0, `dbg_data`=0, queue empty, in-flight flag clear, `fetch_pc`=`RESET_PC`. `rom_en`=0 while `rst` is high and in BOOT.
- **Issue (RUN only):** a fetch is issued when `(count + inflight - pop) < 2`, there is no redirect, and there is no debug grant.
  - `pop` = `inst_valid & inst_ready`.
  - On issue: `rom_en`=1, the in-flight tag is set to `fetch_pc`, and `fetch_pc` advances by 4.
- **Response:** one cycle after an issue, `{rom_data, tag}` is written into the queue tail, unless a redirect is active that cycle.
- **Queue:** 2 entries, FIFO order. Outputs `inst`/`inst_pc` come from the head. Simultaneous push and pop is legal. Overflow is impossible by the credit rule.
- **Redirect in cycle t:**
  - No issue in cycle t.
  - The response present in cycle t is discarded.
  - The queue is cleared at the end of cycle t. A pop in cycle t counts as consumed.
  - `fetch_pc` ← `{redirect_pc[31:2], 2'b00}`.
  - A redirect during BOOT is honoured.
- **Arithmetic:** `fetch_pc` is 32-bit and wraps modulo 2^32. The ROM index wraps modulo 2^AW implicitly.
- **Priority:** redirect > debug > fetch.

## Timing

- **Fetch latency:** issue at cycle c gives ROM data at c+1, written to the queue at end of c+1, and `inst_valid` at c+2 (if ahead of nothing in the queue).
- **Boot:** `rst` falls before cycle 0. Cycle 0 is BOOT, cycle 1 issues `RESET_PC`, and the first `inst_valid` is at cycle 3.
- **Redirect at t:** `inst_valid`=0 in t+1 and t+2; the target issues in t+1; target `inst_valid` at t+3.
- **Throughput:** 1 instruction/cycle sustained with `inst_ready`=1.
- **Backpressure:** with `inst_ready`=0, at most 2 words are buffered and `rom_en` drops. Head outputs stay stable while `inst_valid & !inst_ready`.
- **Reset mid-operation:** everything returns to reset values on the next edge. Any in-flight response is discarded.

## Configuration

- **`IFETCH_DBG_EN` defined:** the debug port is active.
  - When `dbg_req` is high, no debug read is outstanding, `dbg_ack` is low this cycle, and there is no redirect: the debug read is issued (`rom_en`=1, `rom_addr`=`dbg_addr`).
  - The fetch slot for that cycle is lost; `fetch_pc` does not advance.
  - Next cycle: `dbg_ack`=1 and `dbg_data`=`rom_data` for one cycle. The debug response never enters the queue.
  - The requester drops `dbg_req` in the ack cycle.
- **`IFETCH_DBG_EN` undefined:** no debug logic. `dbg_ack` and `dbg_data` are tied 0, and `dbg_req`/`dbg_addr` are ignored.

## Test plan

- **Boot:** `RESET_PC`=0, ROM[k]=32'h1000_0000+k, `inst_ready`=1 → `inst_valid` from cycle 3; `inst_pc`=0,4,8,…; `inst`=32'h1000_0000,32'h1000_0001,… one per cycle with no gaps.
- **Backpressure:** `inst_ready`=0 for 5 cycles mid-stream → head stable, `rom_en`=0 once 2 words are buffered; after release, PCs continue with no loss or duplication.
- **Redirect:** redirect to 32'h0000_0043 at t, `inst_ready`=1 → `inst_valid`=0 at t+1/t+2; `inst_pc`=32'h40 and `inst`=ROM[16] at t+3.
- **Redirect with full queue:** queue full and `inst_ready`=0 when redirect fires → both entries dropped; first output is the target.
- **Wrap:** `AW`=10, `RESET_PC`=32'hFFC → `rom_addr` sequence 1023, 0, 1; `inst_pc` 32'hFFC, 32'h1000, 32'h1004.
- **Debug (`IFETCH_DBG_EN`):** `dbg_req` at t with `dbg_addr`=5 during streaming → `dbg_ack`=1 with `dbg_data`=32'h1000_0005 at t+1; exactly one fetch bubble; fetch order is preserved; `rst` asserted mid-run clears `dbg_ack` and the queue.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives a 1-cycle-latency ROM and
// feeds decode through a 2-entry queue. Optional debug ROM read port: `IFETCH_DBG_EN`.
module ifetch_ctrl #(
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [31:0]   rom_data,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic [31:0]   dbg_data
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] tag_q, tag_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] q0_data_q, q0_data_d;
    logic [31:0] q0_pc_q, q0_pc_d;
    logic [31:0] q1_data_q, q1_data_d;
    logic [31:0] q1_pc_q, q1_pc_d;

    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic        dbg_grant_s;
    logic [2:0]  credit_s;
    logic        unused_pc_bits_s;

    assign unused_pc_bits_s = ^redirect_pc[1:0];

    assign inst_valid = (count_q != 2'd0);
    assign inst       = q0_data_q;
    assign inst_pc    = q0_pc_q;

`ifdef IFETCH_DBG_EN
    logic dbg_ack_q, dbg_ack_d;

    // Debug read steals the ROM port from the fetch stream for one cycle.
    always_comb begin
        dbg_grant_s = 1'b0;
        if (!rst && (state_q == ST_RUN) && dbg_req && !dbg_ack_q && !redirect_valid) begin
            dbg_grant_s = 1'b1;
        end else begin
            dbg_grant_s = 1'b0;
        end
        dbg_ack_d = dbg_grant_s;
    end

    // Acknowledge lines up with the ROM data of the granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_ack_q <= 1'b0;
        end else begin
            dbg_ack_q <= dbg_ack_d;
        end
    end

    assign dbg_ack  = dbg_ack_q;
    assign dbg_data = dbg_ack_q ? rom_data : 32'h0000_0000;
`else
    logic unused_dbg_s;

    assign unused_dbg_s = dbg_req;
    assign dbg_grant_s  = 1'b0;
    assign dbg_ack      = 1'b0;
    assign dbg_data     = 32'h0000_0000;
`endif

    // BOOT is a single dead cycle after reset; RUN holds until the next reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // Credit rule: buffered plus in-flight words, after this cycle's pop, stay below two.
    always_comb begin
        pop_s    = inst_valid & inst_ready;
        credit_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s  = 1'b0;
        if (!rst && (state_q == ST_RUN) && !redirect_valid && !dbg_grant_s && (credit_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        push_s   = inflight_q & ~redirect_valid;
        rom_en   = issue_s | dbg_grant_s;
        rom_addr = dbg_grant_s ? dbg_addr : fetch_pc_q[AW+1:2];
    end

    // Fetch PC and the tag travelling with the outstanding ROM read.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        inflight_d = issue_s;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_d      = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Two-entry shift queue; entry 0 is always the head seen by decode.
    always_comb begin
        q0_data_d = q0_data_q;
        q0_pc_d   = q0_pc_q;
        q1_data_d = q1_data_q;
        q1_pc_d   = q1_pc_q;
        count_d   = count_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b01: begin
                    q0_data_d = q1_data_q;
                    q0_pc_d   = q1_pc_q;
                    count_d   = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q0_data_d = rom_data;
                        q0_pc_d   = tag_q;
                    end else begin
                        q1_data_d = rom_data;
                        q1_pc_d   = tag_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        q0_data_d = q1_data_q;
                        q0_pc_d   = q1_pc_q;
                        q1_data_d = rom_data;
                        q1_pc_d   = tag_q;
                    end else begin
                        q0_data_d = rom_data;
                        q0_pc_d   = tag_q;
                    end
                    count_d = count_q;
                end
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset also drops any response still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC_ALIGNED;
            tag_q      <= 32'h0000_0000;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            q0_data_q  <= 32'h0000_0000;
            q0_pc_q    <= 32'h0000_0000;
            q1_data_q  <= 32'h0000_0000;
            q1_pc_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            q0_data_q  <= q0_data_d;
            q0_pc_q    <= q0_pc_d;
            q1_data_q  <= q1_data_d;
            q1_pc_q    <= q1_pc_d;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected fetch streams are queued by the stimulus,
// a negedge monitor checks ROM issue, queue head, handshake timing and debug reads.
module tb_ifetch_ctrl;
    localparam int          AW        = 10;
    localparam logic [31:0] RST_PC    = 32'h0000_0FFC;
    localparam logic [31:0] RST_PC_AL = {RST_PC[31:2], 2'b00};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data = 32'h0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          dbg_req = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic          dbg_ack;
    logic [31:0]   dbg_data;

    ifetch_ctrl #(.AW(AW), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] epoch;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stim_epoch = 32'd0;
    logic [31:0] stim_pc    = RST_PC_AL;
    int          stim_quiet = 0;
    logic        prev_dreq  = 1'b0;
    int          pops       = 0;

    // Keep a few sequential PCs of the current stream queued ahead of the monitor.
    task automatic topup();
        int n;
        n = 0;
        foreach (exp_q[i]) if (exp_q[i].epoch == stim_epoch) n++;
        while (n < 6) begin
            exp_q.push_back('{epoch: stim_epoch, pc: stim_pc});
            stim_pc = stim_pc + 32'd4;
            n++;
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc,
                         input logic dreq, input logic [AW-1:0] da);
        @(posedge clk);
        #1;
        rst            = r;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dbg_req        = dreq;
        dbg_addr       = da;
        if (r) begin
            stim_epoch = stim_epoch + 32'd1;
            stim_pc    = RST_PC_AL;
            stim_quiet = 0;
        end else if (redir) begin
            stim_epoch = stim_epoch + 32'd1;
            stim_pc    = {rpc[31:2], 2'b00};
            stim_quiet = 0;
        end else begin
            stim_quiet++;
        end
        topup();
        prev_dreq = dreq;
    endtask

    // Monitor: samples each cycle at the falling edge, after inputs and outputs have settled.
    initial begin : monitor
        logic          prev_rst;
        logic          exp_ack;
        logic          grant;
        logic          pop;
        logic          exp_en;
        logic [AW-1:0] last_daddr;
        logic [31:0]   mon_epoch;
        logic [31:0]   issue_pc_m;
        logic [31:0]   head_pc;
        int            outstanding;
        int            since_flush;
        int            since_dbg;
        prev_rst    = 1'b1;
        exp_ack     = 1'b0;
        last_daddr  = '0;
        mon_epoch   = 32'd0;
        issue_pc_m  = RST_PC_AL;
        outstanding = 0;
        since_flush = -1;
        since_dbg   = 100;
        forever begin
            @(negedge clk);
            grant = 1'b0;
`ifdef IFETCH_DBG_EN
            grant = dbg_req && !rst && !redirect_valid && !prev_rst && !exp_ack;
`endif
            pop = inst_valid && inst_ready;

            if (prev_rst && !rst) begin
                chk32("reset_inst", inst, 32'h0);
                chk32("reset_inst_pc", inst_pc, 32'h0);
            end

            chk1("dbg_ack", dbg_ack, exp_ack);
`ifdef IFETCH_DBG_EN
            if (exp_ack) chk32("dbg_data", dbg_data, rom_word(last_daddr));
`else
            chk32("dbg_data_tied", dbg_data, 32'h0);
`endif

            if (rst || redirect_valid || prev_rst) exp_en = 1'b0;
            else if (grant) exp_en = 1'b1;
            else exp_en = ((outstanding - (pop ? 1 : 0)) < 2);
            chk1("rom_en", rom_en, exp_en);
            if (rom_en && exp_en) begin
                if (grant) chk32("rom_addr_dbg", 32'(rom_addr), 32'(dbg_addr));
                else chk32("rom_addr", 32'(rom_addr), 32'(issue_pc_m[AW+1:2]));
            end

            if (since_flush < 2) chk1("inst_valid_after_flush", inst_valid, 1'b0);
            else if (since_dbg >= 2) chk1("inst_valid_stream", inst_valid, 1'b1);

            while (exp_q.size() > 0 && exp_q[0].epoch < mon_epoch) void'(exp_q.pop_front());
            if (inst_valid) begin
                if (exp_q.size() == 0 || exp_q[0].epoch != mon_epoch) begin
                    checks++;
                    errors++;
                    $display("FAIL head_expected: got pc %h, scoreboard has no entry at %0t", inst_pc, $time);
                end else begin
                    head_pc = exp_q[0].pc;
                    chk32("inst_pc", inst_pc, head_pc);
                    chk32("inst", inst, rom_word(head_pc[AW+1:2]));
                    if (inst_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end

            if (grant) last_daddr = dbg_addr;
            if (rst) begin
                mon_epoch   = mon_epoch + 32'd1;
                outstanding = 0;
                issue_pc_m  = RST_PC_AL;
                since_flush = -1;
            end else if (redirect_valid) begin
                mon_epoch   = mon_epoch + 32'd1;
                outstanding = 0;
                issue_pc_m  = {redirect_pc[31:2], 2'b00};
                since_flush = 0;
            end else begin
                outstanding = outstanding - (pop ? 1 : 0) + ((exp_en && !grant) ? 1 : 0);
                if (exp_en && !grant) issue_pc_m = issue_pc_m + 32'd4;
                if (since_flush < 100) since_flush++;
            end
            if (grant) since_dbg = 0;
            else if (since_dbg < 100) since_dbg++;
            exp_ack  = grant;
            prev_rst = rst;
        end
    end

    initial begin : stimulus
        repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, '0);
        // boot from 0xFFC: ROM index wraps 1023 -> 0 -> 1
        repeat (20) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0043, 1'b0, '0);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        // redirect while the queue is full and stalled
        repeat (4) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, '0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0);
        repeat (8) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, '0);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        // debug read mid-stream, then a debug request colliding with reset
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 10'd5);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 10'd7);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        // redirect during BOOT
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, '0);
        repeat (8) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        for (int i = 0; i < 3000; i++) begin
            logic          r;
            logic          rd;
            logic          dq;
            logic [31:0]   rp;
            logic [AW-1:0] da;
            r  = ($urandom_range(0, 399) == 0);
            rd = ($urandom_range(0, 29) == 0);
            rp = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 8191);
            da = AW'($urandom_range(0, 1023));
            dq = !r && !rd && !prev_dreq && (stim_quiet >= 1) && ($urandom_range(0, 11) == 0);
            drive(r, ($urandom_range(0, 3) != 0), rd, rp, dq, da);
        end
        repeat (6) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
        @(negedge clk);
        #1;
        chk1("instructions_delivered", (pops > 500), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
